// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: read-side bus of the PS/2 receiver FIFO.
//   slave  : the receiver. It drives rd_data/rd_valid/fifo_count/overflow/frame_err
//            and takes in rd_ready/clr_err.
//   master : the consumer. It drives rd_ready (pop) and clr_err (clear the sticky flags).
interface ps2_rx_fifo_if #(
  parameter int DEPTH = 8
);
  logic                     rd_ready;
  logic                     clr_err;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     frame_err;

  modport master (
    output rd_ready, clr_err,
    input  rd_data, rd_valid, fifo_count, overflow, frame_err
  );

  modport slave (
    input  rd_ready, clr_err,
    output rd_data, rd_valid, fifo_count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with a first-word-fall-through scan-code FIFO.
//   clk      : system clock. All state changes on the rising edge.
//   resetn   : asynchronous active-low reset.
//   ps2_clk  : raw PS/2 clock. It is asynchronous and is synchronised here.
//   ps2_data : raw PS/2 data. It is asynchronous and is synchronised here.
//   bus      : read side (slave). Carries rd_data/rd_valid/rd_ready pop,
//              fifo_count, the sticky overflow/frame_err flags and clr_err.
// Each frame has 11 bits, sent LSB first: start, 8 data bits, odd parity, stop.
// Good frames are pushed into the FIFO. Bad frames and timed-out frames set frame_err.
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 50000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Synchronisers. They are preset to 1 (idle bus), so releasing reset never
  // produces a false falling edge.
  logic [SYNC_STAGES-1:0] cs_q, ds_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_q   <= '1;
      ds_q   <= '1;
      prev_q <= 1'b1;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], ps2_clk};
      ds_q   <= {ds_q[SYNC_STAGES-2:0], ps2_data};
      prev_q <= cs_q[SYNC_STAGES-1];
    end
  end

  logic fall, din;
  assign fall = prev_q & ~cs_q[SYNC_STAGES-1];
  assign din  = ds_q[SYNC_STAGES-1];

  // Deframer and timeout
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   sh_q, sh_d, frame;
  logic [TW-1:0] to_q, to_d;
  logic          commit, good, bad, to_hit;

  // frame is the shift register as it will look after this fall. At commit it
  // already holds the stop bit, so the frame can be checked in the same cycle.
  assign frame  = {din, sh_q[10:1]};
  assign commit = fall && (bit_cnt_q == 4'd10);
  assign good   = commit && !frame[0] && frame[10] && (^frame[9:1]);
  assign bad    = commit && !good;
  assign to_hit = !fall && (bit_cnt_q != 4'd0) && (to_q == TW'(TIMEOUT - 1));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    to_d      = to_q + TW'(1);
    if (fall) begin
      sh_d      = frame;
      bit_cnt_d = commit ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (to_hit) begin
      bit_cnt_d = 4'd0;
    end
    if (fall || (bit_cnt_q == 4'd0) || to_hit) to_d = '0;
  end

  // FIFO
  logic [DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  pop, push, drop;
  logic                  ovf_q, ovf_d, ferr_q, ferr_d;

  assign pop  = (count_q != '0) && bus.rd_ready;
  // A pop in the same cycle frees the slot, so a push is accepted even when the FIFO is full.
  assign push = good && ((count_q < CW'(DEPTH)) || pop);
  assign drop = good && !push;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // clr_err wins over an error that occurs in the same cycle
    ovf_d  = bus.clr_err ? 1'b0 : (ovf_q  | drop);
    ferr_d = bus.clr_err ? 1'b0 : (ferr_q | bad | to_hit);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      to_q      <= '0;
      mem_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      to_q      <= to_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      if (push) begin
        mem_q[wptr_q] <= frame[8:1];
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
    end
  end

  assign bus.rd_data    = mem_q[rptr_q];
  assign bus.rd_valid   = (count_q != '0);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = ferr_q;
endmodule
